// File: rtl/wb_trap_redirect_pkg.sv
// Shared writeback constants: RV32 opcodes, load funct3 encodings and the
// rd-writing opcode classifier.
package wb_trap_redirect_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // SYSTEM with funct3==0 is ecall/ebreak/mret and never produces an rd value.
  function automatic logic writes_rd(input logic [6:0] opcode, input logic [2:0] funct3);
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_LOAD: writes_rd = 1'b1;
      OPC_SYSTEM:                  writes_rd = (funct3 != 3'b000);
      default:                     writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_trap_redirect_load_formatter.sv
// Combinational load formatter: picks the addressed byte/half from an aligned
// word and sign- or zero-extends it according to funct3.
module wb_trap_redirect_load_formatter
  import wb_trap_redirect_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    case (addr)
      2'd0: b = raw[7:0];
      2'd1: b = raw[15:8];
      2'd2: b = raw[23:16];
      2'd3: b = raw[31:24];
      default: b = 8'h00;
    endcase
    h = addr[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    data = 32'h0;
    case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LBU:  data = {24'h0, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LHU:  data = {16'h0, h};
      F3_LW:   data = raw;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/wb_trap_redirect.sv
// Writeback stage: rd result select, register-file write, retire pulse, and
// trap/mret redirect followed by a bounded flush window.
module wb_trap_redirect
  import wb_trap_redirect_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce,
  input  logic        i_stall,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_alu_y,
  input  logic [31:0] i_load_data,
  input  logic [31:0] i_csr_out,
  input  logic        i_go_to_trap_q,
  input  logic        i_return_from_trap_q,
  input  logic [31:0] i_trap_address,
  input  logic [31:0] i_return_address,
  output logic        o_wr_rd,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_change_pc,
  output logic [31:0] o_next_pc,
  output logic        o_flush,
  output logic        o_minstret_inc
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REDIRECT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic        acc;
  logic        redirect;
  logic [31:0] load_val;
  logic [31:0] link;
  logic [31:0] result;

  assign acc      = i_ce & ~i_stall & (state == S_IDLE);
  assign redirect = i_go_to_trap_q | i_return_from_trap_q;
  assign link     = i_pc + 32'd4;

  wb_trap_redirect_load_formatter u_fmt (
    .raw    (i_load_data),
    .addr   (i_alu_y[1:0]),
    .funct3 (i_funct3),
    .data   (load_val)
  );

  always_comb begin
    result = i_alu_y;
    case (i_opcode)
      OPC_LOAD:          result = load_val;
      OPC_SYSTEM:        result = (i_funct3 != 3'b000) ? i_csr_out : i_alu_y;
      OPC_JAL, OPC_JALR: result = link;
      default:           result = i_alu_y;
    endcase
  end

  // Flush is taken straight from the state register so it covers the redirect
  // cycle plus FLUSH_CYCLES, and drops immediately on async reset.
  assign o_flush = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_rd        <= 1'b0;
      o_rd_addr      <= 5'd0;
      o_rd_data      <= 32'h0;
      o_change_pc    <= 1'b0;
      o_next_pc      <= RESET_PC;
      o_minstret_inc <= 1'b0;
      state          <= S_IDLE;
      cnt            <= 3'd0;
    end else begin
      o_wr_rd        <= acc & ~i_go_to_trap_q & (i_rd_addr != 5'd0) & writes_rd(i_opcode, i_funct3);
      o_minstret_inc <= acc & ~i_go_to_trap_q;
      o_change_pc    <= acc & redirect;
      if (acc) begin
        o_rd_addr <= i_rd_addr;
        o_rd_data <= result;
      end
      if (acc & redirect)
        o_next_pc <= i_go_to_trap_q ? i_trap_address : i_return_address;

      case (state)
        S_IDLE: if (acc & redirect) begin
          state <= S_REDIRECT;
          cnt   <= 3'(FLUSH_CYCLES);
        end
        S_REDIRECT: state <= S_FLUSH;
        S_FLUSH: begin
          if (cnt <= 3'd1) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trap_redirect.sv
// Scoreboard bench for wb_trap_redirect: directed instructions push expected
// writeback events; a negedge monitor pops and compares each presented event.
module tb_wb_trap_redirect;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;

  localparam logic [6:0] LOAD = 7'b0000011, SYSTEM = 7'b1110011, JAL = 7'b1101111,
                         JALR = 7'b1100111, OP = 7'b0110011, LUI = 7'b0110111,
                         STORE = 7'b0100011;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_ce, i_stall;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_pc, i_alu_y, i_load_data, i_csr_out;
  logic        i_go_to_trap_q, i_return_from_trap_q;
  logic [31:0] i_trap_address, i_return_address;
  logic        o_wr_rd, o_change_pc, o_flush, o_minstret_inc;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data, o_next_pc;

  wb_trap_redirect #(.FLUSH_CYCLES(FLUSH_CYCLES), .RESET_PC(RESET_PC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce), .i_stall(i_stall),
    .i_opcode(i_opcode), .i_funct3(i_funct3), .i_rd_addr(i_rd_addr), .i_pc(i_pc),
    .i_alu_y(i_alu_y), .i_load_data(i_load_data), .i_csr_out(i_csr_out),
    .i_go_to_trap_q(i_go_to_trap_q), .i_return_from_trap_q(i_return_from_trap_q),
    .i_trap_address(i_trap_address), .i_return_address(i_return_address),
    .o_wr_rd(o_wr_rd), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
    .o_change_pc(o_change_pc), .o_next_pc(o_next_pc), .o_flush(o_flush),
    .o_minstret_inc(o_minstret_inc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        chg;
    logic [31:0] npc;
    logic        minst;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_npc = RESET_PC;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any write, retire or redirect pulse is a presented event.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && (o_wr_rd || o_change_pc || o_minstret_inc)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: wr=%b chg=%b minst=%b expected none at %0t",
                   o_wr_rd, o_change_pc, o_minstret_inc, $time);
        end else begin
          e = q.pop_front();
          chk("wr_rd", 32'(o_wr_rd), 32'(e.wr));
          chk("change_pc", 32'(o_change_pc), 32'(e.chg));
          chk("minstret", 32'(o_minstret_inc), 32'(e.minst));
          chk("next_pc", o_next_pc, e.npc);
          if (e.wr) begin
            chk("rd_addr", 32'(o_rd_addr), 32'(e.addr));
            chk("rd_data", o_rd_data, e.data);
          end
        end
      end
    end
  end

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] aluy, input logic [31:0] ld,
                       input logic [31:0] csr, input logic trap, input logic mret,
                       input logic [31:0] ta, input logic [31:0] ra);
    i_ce = 1'b1; i_opcode = opc; i_funct3 = f3; i_rd_addr = rd; i_pc = pc;
    i_alu_y = aluy; i_load_data = ld; i_csr_out = csr;
    i_go_to_trap_q = trap; i_return_from_trap_q = mret;
    i_trap_address = ta; i_return_address = ra;
  endtask

  task automatic push(input logic wr, input logic [4:0] rd, input logic [31:0] data,
                      input logic chg, input logic minst);
    exp_t e;
    e.wr = wr; e.addr = rd; e.data = data; e.chg = chg; e.npc = exp_npc; e.minst = minst;
    q.push_back(e);
  endtask

  // One accepted instruction; expected values are hand-computed by the caller.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] aluy, input logic [31:0] ld,
                       input logic [31:0] csr, input logic trap, input logic mret,
                       input logic [31:0] ta, input logic [31:0] ra,
                       input logic ewr, input logic [31:0] edata, input logic eminst);
    drive(opc, f3, rd, pc, aluy, ld, csr, trap, mret, ta, ra);
    if (trap) exp_npc = ta;
    else if (mret) exp_npc = ra;
    push(ewr, rd, edata, trap | mret, eminst);
    @(posedge i_clk); #1;
    i_ce = 1'b0; i_go_to_trap_q = 1'b0; i_return_from_trap_q = 1'b0;
  endtask

  initial begin
    int n;
    i_rst_n = 1'b0; i_ce = 1'b0; i_stall = 1'b0;
    drive(OP, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    i_ce = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_wr_rd", 32'(o_wr_rd), 32'd0);
    chk("rst_rd_data", o_rd_data, 32'h0);
    chk("rst_next_pc", o_next_pc, RESET_PC);
    chk("rst_flush", 32'(o_flush), 32'd0);
    chk("rst_change_pc", 32'(o_change_pc), 32'd0);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Loads from word 80FF_7F01
    issue(LOAD, 3'b000, 5'd5, 32'h40, 32'h1003, 32'h80FF_7F01, 32'h0, 0, 0, 0, 0, 1, 32'hFFFF_FF80, 1);
    issue(LOAD, 3'b101, 5'd6, 32'h44, 32'h1002, 32'h80FF_7F01, 32'h0, 0, 0, 0, 0, 1, 32'h0000_80FF, 1);
    issue(LOAD, 3'b001, 5'd7, 32'h48, 32'h1000, 32'h80FF_7F01, 32'h0, 0, 0, 0, 0, 1, 32'h0000_7F01, 1);
    issue(LOAD, 3'b010, 5'd8, 32'h4C, 32'h1000, 32'h80FF_7F01, 32'h0, 0, 0, 0, 0, 1, 32'h80FF_7F01, 1);
    issue(LOAD, 3'b011, 5'd9, 32'h50, 32'h1000, 32'h80FF_7F01, 32'h0, 0, 0, 0, 0, 1, 32'h0000_0000, 1);
    issue(LOAD, 3'b100, 5'd10, 32'h54, 32'h1001, 32'h80FF_7F01, 32'h0, 0, 0, 0, 0, 1, 32'h0000_007F, 1);
    issue(LOAD, 3'b001, 5'd11, 32'h58, 32'h1002, 32'h80FF_7F01, 32'h0, 0, 0, 0, 0, 1, 32'hFFFF_80FF, 1);

    // Link wrap-around, rd=0, CSR read, store, plain ALU
    issue(JAL, 3'b000, 5'd1, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h0000_0000, 1);
    issue(JALR, 3'b000, 5'd0, 32'h100, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1);
    issue(SYSTEM, 3'b001, 5'd12, 32'h104, 32'h55, 32'h0, 32'hCAFE_0001, 0, 0, 0, 0, 1, 32'hCAFE_0001, 1);
    issue(STORE, 3'b010, 5'd13, 32'h108, 32'h77, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1);
    issue(LUI, 3'b000, 5'd14, 32'h10C, 32'hABCD_E000, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'hABCD_E000, 1);

    // Trap with i_ce held through the flush window
    issue(OP, 3'b000, 5'd3, 32'h110, 32'h33, 32'h0, 32'h0, 1, 0, 32'h100, 32'h0, 0, 32'h0, 0);
    drive(OP, 3'b000, 5'd7, 32'h114, 32'h77, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    n = 0;
    repeat (3) begin
      @(negedge i_clk);
      if (o_flush) n++;
      @(posedge i_clk); #1;
    end
    i_ce = 1'b0;
    repeat (2) begin
      @(negedge i_clk);
      if (o_flush) n++;
    end
    chk("flush_cycles", 32'(n), 32'(1 + FLUSH_CYCLES));
    @(posedge i_clk); #1;

    // Trap and mret together, then mret alone
    issue(OP, 3'b000, 5'd4, 32'h120, 32'h0, 32'h0, 32'h0, 1, 1, 32'h100, 32'h200, 0, 32'h0, 0);
    repeat (4) @(posedge i_clk); #1;
    issue(SYSTEM, 3'b000, 5'd0, 32'h124, 32'h0, 32'h0, 32'h0, 0, 1, 32'h100, 32'h200, 0, 32'h0, 1);
    repeat (4) @(posedge i_clk); #1;

    // Stall for three cycles, then a single write
    drive(OP, 3'b000, 5'd9, 32'h130, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    i_stall = 1'b1;
    repeat (3) @(posedge i_clk); #1;
    i_stall = 1'b0;
    push(1'b1, 5'd9, 32'h0000_1234, 1'b0, 1'b1);
    @(posedge i_clk); #1;
    i_ce = 1'b0;
    repeat (2) @(posedge i_clk); #1;

    // Async reset during the second flush cycle
    issue(OP, 3'b000, 5'd2, 32'h140, 32'h0, 32'h0, 32'h0, 1, 0, 32'h300, 32'h0, 0, 32'h0, 0);
    @(posedge i_clk);
    @(posedge i_clk); #2;
    chk("flush_before_rst", 32'(o_flush), 32'd1);
    i_rst_n = 1'b0;
    exp_npc = RESET_PC;
    #1;
    chk("midrst_flush", 32'(o_flush), 32'd0);
    chk("midrst_next_pc", o_next_pc, RESET_PC);
    chk("midrst_rd_addr", 32'(o_rd_addr), 32'd0);
    chk("midrst_rd_data", o_rd_data, 32'h0);
    chk("midrst_wr_minst_chg", {29'd0, o_wr_rd, o_minstret_inc, o_change_pc}, 32'd0);
    @(negedge i_clk) i_rst_n = 1'b1;
    drive(OP, 3'b000, 5'd4, 32'h200, 32'h0000_4444, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    push(1'b1, 5'd4, 32'h0000_4444, 1'b0, 1'b1);
    @(posedge i_clk); #1;
    chk("post_rst_first_accept", 32'(o_wr_rd), 32'd1);
    i_ce = 1'b0;

    repeat (3) @(posedge i_clk); #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
